// File: rtl/alarm_ring_ctrl.sv
// Alarm match / ring / snooze controller driving a passive buzzer with a gated tone.
// Define SNOOZE_LIMIT_EN to cap accepted snoozes per alarm event at MAX_SNOOZE.
module alarm_ring_ctrl #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TONE_DIV   = 12_500,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_bcd,
  input  logic [23:0] alarm,
  input  logic        alarm_ready,
  input  logic        tick_1s,
  input  logic        stop_filtered,
  input  logic        snooze_filtered,
  output logic        buzzer,
  output logic        ringing,
  output logic        alarm_hit,
  output logic [1:0]  alarm_state
);

  localparam int unsigned HALF_SEC = CLK_FREQ / 2;
  localparam int unsigned RC_W     = $clog2(RING_SEC) + 1;
  localparam int unsigned SN_W     = $clog2(SNOOZE_SEC) + 1;
  localparam int unsigned TD_W     = $clog2(TONE_DIV) + 1;
  localparam int unsigned GD_W     = $clog2(HALF_SEC) + 1;

  if (CLK_FREQ < 2 || TONE_DIV == 0 || RING_SEC == 0 || SNOOZE_SEC == 0 || MAX_SNOOZE == 0) begin : g_bad_param
    $error("alarm_ring_ctrl: parameters out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_RING   = 2'b10,
    ST_SNOOZE = 2'b11
  } state_t;

  state_t          state, state_n;
  logic            match_q;
  logic [RC_W-1:0] ring_cnt;
  logic [SN_W-1:0] snz_cnt;
  logic [TD_W-1:0] tone_cnt;
  logic [GD_W-1:0] gate_cnt;
  logic            tone, gate;

  logic valid_c, match_c, hit_c, ring_done_c, snz_done_c, snooze_ok_c;
  logic enter_ring_c, stay_ring_c;

  assign valid_c      = alarm_ready && (alarm != 24'hFFFFFF);
  assign match_c      = (time_bcd == alarm);
  assign hit_c        = match_c && !match_q;
  assign ring_done_c  = tick_1s && (ring_cnt == RC_W'(RING_SEC - 1));
  assign snz_done_c   = tick_1s && (snz_cnt == SN_W'(SNOOZE_SEC - 1));
  assign enter_ring_c = (state_n == ST_RING) && (state != ST_RING);
  assign stay_ring_c  = (state_n == ST_RING) && (state == ST_RING);

  // Next state; losing valid overrides every other event, stop beats snooze.
  always_comb begin
    state_n = state;
    if (!valid_c) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   state_n = ST_ARMED;
        ST_ARMED:  if (hit_c) state_n = ST_RING;
        ST_RING: begin
          if (stop_filtered || ring_done_c)          state_n = ST_ARMED;
          else if (snooze_filtered && snooze_ok_c)   state_n = ST_SNOOZE;
        end
        ST_SNOOZE: begin
          if (stop_filtered)   state_n = ST_ARMED;
          else if (snz_done_c) state_n = ST_RING;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      match_q     <= 1'b0;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      tone_cnt    <= '0;
      gate_cnt    <= '0;
      tone        <= 1'b0;
      gate        <= 1'b0;
      buzzer      <= 1'b0;
      ringing     <= 1'b0;
      alarm_hit   <= 1'b0;
      alarm_state <= 2'b00;
    end else begin
      state       <= state_n;
      match_q     <= match_c;
      alarm_state <= state_n;
      ringing     <= (state_n == ST_RING);
      alarm_hit   <= (state == ST_ARMED) && (state_n == ST_RING);
      // Registered from the current tone/gate, so the first high lands one cycle after entry.
      buzzer      <= stay_ring_c && tone && gate;

      if (enter_ring_c) begin
        ring_cnt <= '0;
        tone_cnt <= '0;
        gate_cnt <= '0;
        tone     <= 1'b1;
        gate     <= 1'b1;
      end else if (stay_ring_c) begin
        if (tick_1s) ring_cnt <= ring_cnt + RC_W'(1);
        if (tone_cnt == TD_W'(TONE_DIV - 1)) begin
          tone_cnt <= '0;
          tone     <= ~tone;
        end else begin
          tone_cnt <= tone_cnt + TD_W'(1);
        end
        if (gate_cnt == GD_W'(HALF_SEC - 1)) begin
          gate_cnt <= '0;
          gate     <= ~gate;
        end else begin
          gate_cnt <= gate_cnt + GD_W'(1);
        end
      end

      if ((state_n == ST_SNOOZE) && (state != ST_SNOOZE)) begin
        snz_cnt <= '0;
      end else if ((state == ST_SNOOZE) && (state_n == ST_SNOOZE) && tick_1s) begin
        snz_cnt <= snz_cnt + SN_W'(1);
      end
    end
  end

`ifdef SNOOZE_LIMIT_EN
  localparam int unsigned SC_W = $clog2(MAX_SNOOZE) + 1;
  logic [SC_W-1:0] snooze_cnt;

  // Accepted snoozes in the current alarm event; cleared whenever ARMED is re-entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snooze_cnt <= '0;
    end else if ((state_n == ST_ARMED) && (state != ST_ARMED)) begin
      snooze_cnt <= '0;
    end else if ((state == ST_RING) && (state_n == ST_SNOOZE)) begin
      snooze_cnt <= snooze_cnt + SC_W'(1);
    end
  end

  assign snooze_ok_c = (snooze_cnt < SC_W'(MAX_SNOOZE));
`else
  assign snooze_ok_c = 1'b1;
`endif

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares state/ringing/buzzer and alarm_hit pulse cycles.
module tb_alarm_ring_ctrl;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ARMED  = 2'b01;
  localparam logic [1:0] S_RING   = 2'b10;
  localparam logic [1:0] S_SNOOZE = 2'b11;
  localparam int TICK_GAP = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] time_bcd;
  logic [23:0] alarm;
  logic        alarm_ready;
  logic        tick_1s;
  logic        stop_filtered;
  logic        snooze_filtered;
  logic        buzzer;
  logic        ringing;
  logic        alarm_hit;
  logic [1:0]  alarm_state;

  alarm_ring_ctrl #(
    .CLK_FREQ  (20),
    .TONE_DIV  (2),
    .RING_SEC  (3),
    .SNOOZE_SEC(2),
    .MAX_SNOOZE(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .time_bcd       (time_bcd),
    .alarm          (alarm),
    .alarm_ready    (alarm_ready),
    .tick_1s        (tick_1s),
    .stop_filtered  (stop_filtered),
    .snooze_filtered(snooze_filtered),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .alarm_hit      (alarm_hit),
    .alarm_state    (alarm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       chk_bz;
    logic       bz;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   hit_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic done = 1'b0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic ok, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: compares whatever the scoreboard holds for this cycle, plus every alarm_hit pulse.
  always @(negedge clk) begin
    if (!done) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk(e.nm,
            (alarm_state === e.st) && (ringing === (e.st == S_RING)) && (!e.chk_bz || buzzer === e.bz),
            {29'd0, buzzer, ringing, alarm_state},
            {29'd0, e.chk_bz ? e.bz : buzzer, (e.st == S_RING), e.st});
      end
      if (hit_q.size() > 0 && hit_q[0] < cyc) begin
        chk("hit_missed", 1'b0, 32'(cyc), 32'(hit_q[0]));
        void'(hit_q.pop_front());
      end
      if (alarm_hit === 1'b1) begin
        if (hit_q.size() == 0) begin
          chk("hit_unexpected", 1'b0, 32'(cyc), 32'd0);
        end else begin
          chk("hit_cycle", hit_q[0] == cyc, 32'(cyc), 32'(hit_q[0]));
          void'(hit_q.pop_front());
        end
      end
    end else begin
      chk("exp_queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
      chk("hit_queue_drained", hit_q.size() == 0, 32'(hit_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expect state (and optionally buzzer) after d more active edges.
  task automatic exp_push(input string nm, input int d, input logic [1:0] st, input logic chk_bz, input logic bz);
    exp_t x;
    x.cyc    = cyc + d;
    x.st     = st;
    x.chk_bz = chk_bz;
    x.bz     = bz;
    x.nm     = nm;
    exp_q.push_back(x);
  endtask

  task automatic tick_pulse();
    tick_1s = 1'b1;
    step(1);
    tick_1s = 1'b0;
    step(TICK_GAP - 1);
  endtask

  task automatic new_hit(input string nm);
    time_bcd = 24'h070001;
    step(1);
    time_bcd = 24'h070000;
    hit_q.push_back(cyc + 1);
    exp_push(nm, 1, S_RING, 1'b1, 1'b0);
    step(1);
  endtask

  task automatic snooze_press(input string nm, input logic [1:0] st_after);
    snooze_filtered = 1'b1;
    exp_push(nm, 1, st_after, 1'b1, 1'b0);
    step(1);
    snooze_filtered = 1'b0;
  endtask

  task automatic snooze_expire(input string nm);
    exp_push({nm, "_t1"}, 1, S_SNOOZE, 1'b1, 1'b0);
    tick_pulse();
    exp_push({nm, "_rering"}, 1, S_RING, 1'b1, 1'b0);
    exp_push({nm, "_rering_bz"}, 2, S_RING, 1'b1, 1'b1);
    tick_pulse();
  endtask

  initial begin
    rst             = 1'b1;
    alarm_ready     = 1'b1;
    alarm           = 24'hFFFFFF;
    time_bcd        = 24'h065959;
    tick_1s         = 1'b0;
    stop_filtered   = 1'b0;
    snooze_filtered = 1'b0;

    // Reset held, then release with no alarm set.
    exp_push("reset_idle", 1, S_IDLE, 1'b1, 1'b0);
    step(2);
    rst = 1'b0;
    exp_push("no_alarm_idle", 1, S_IDLE, 1'b1, 1'b0);
    exp_push("no_alarm_idle_late", 3, S_IDLE, 1'b1, 1'b0);
    step(3);

    // Reset again, release with a real alarm.
    rst = 1'b1;
    exp_push("reset_again", 1, S_IDLE, 1'b1, 1'b0);
    step(1);
    alarm = 24'h070000;
    step(1);
    rst = 1'b0;
    exp_push("armed", 1, S_ARMED, 1'b1, 1'b0);
    step(2);

    // Minute rollover hits the alarm; check the gated tone over one gate period.
    time_bcd = 24'h070000;
    hit_q.push_back(cyc + 1);
    exp_push("ring_entry", 1, S_RING, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++)
      exp_push($sformatf("buzz_%0d", k), 1 + k, S_RING, 1'b1, ((k - 1) % 4 < 2) && (k <= 10));
    step(21);

    // Auto-stop after three ticks, no retrigger while time stays on the alarm.
    exp_push("ring_after_t1", 1, S_RING, 1'b0, 1'b0);
    tick_pulse();
    exp_push("ring_after_t2", 1, S_RING, 1'b0, 1'b0);
    tick_pulse();
    exp_push("auto_stop", 1, S_ARMED, 1'b1, 1'b0);
    exp_push("no_retrigger", 5, S_ARMED, 1'b1, 1'b0);
    tick_pulse();

    // Stop and snooze together: stop wins.
    new_hit("ring_2");
    step(3);
    stop_filtered   = 1'b1;
    snooze_filtered = 1'b1;
    exp_push("stop_beats_snooze", 1, S_ARMED, 1'b1, 1'b0);
    step(1);
    stop_filtered   = 1'b0;
    snooze_filtered = 1'b0;
    exp_push("stop_beats_snooze_hold", 2, S_ARMED, 1'b1, 1'b0);
    step(2);

    // Snooze, re-ring without alarm_hit, snooze again, stop from SNOOZE.
    new_hit("ring_3");
    step(2);
    snooze_press("snooze_1", S_SNOOZE);
    snooze_expire("snz_1");
    snooze_press("snooze_2", S_SNOOZE);
    stop_filtered = 1'b1;
    exp_push("stop_in_snooze", 1, S_ARMED, 1'b1, 1'b0);
    step(1);
    stop_filtered = 1'b0;
    step(2);

    // Third snooze in one event: capped when the limit is built, accepted otherwise.
    new_hit("ring_4");
    step(2);
    snooze_press("lim_snooze_1", S_SNOOZE);
    snooze_expire("lim_1");
    snooze_press("lim_snooze_2", S_SNOOZE);
    snooze_expire("lim_2");
`ifdef SNOOZE_LIMIT_EN
    snooze_press("lim_snooze_3_ignored", S_RING);
`else
    snooze_press("lim_snooze_3_taken", S_SNOOZE);
`endif
    stop_filtered = 1'b1;
    exp_push("lim_stop", 1, S_ARMED, 1'b1, 1'b0);
    step(1);
    stop_filtered = 1'b0;
    step(2);

    // alarm_ready dropped mid-ring forces IDLE and silences the buzzer.
    new_hit("ring_5");
    step(2);
    alarm_ready = 1'b0;
    exp_push("ready_drop_idle", 1, S_IDLE, 1'b1, 1'b0);
    step(1);
    alarm_ready = 1'b1;
    exp_push("rearm", 1, S_ARMED, 1'b1, 1'b0);
    exp_push("rearm_no_hit", 4, S_ARMED, 1'b1, 1'b0);
    step(6);

    done = 1'b1;
    step(3);
  end

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Consumer end of the alarm-set interface: takes the 24-bit BCD alarm value and the ready flag from the alarm-setting block, plus live BCD time and a 1 s tick from the clock block.
- Detects alarm match, drives a passive buzzer with a pulsed tone, and supports stop/snooze keys.
- Sits between the clock/alarm-set blocks and the buzzer pin; reports its state to the controller.

Parameters:
CLK_FREQ, 50_000_000, clk cycles per second; half-second beep gate = CLK_FREQ/2 cycles
TONE_DIV, 12_500, clk cycles per buzzer half-period (2 kHz at 50 MHz)
RING_SEC, 60, tick_1s pulses of ringing before auto-stop
SNOOZE_SEC, 300, tick_1s pulses of silence before re-ring
MAX_SNOOZE, 3, snoozes allowed per alarm event (used only with SNOOZE_LIMIT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
time_bcd  in  24  current time {h_tens,h_units,m_tens,m_units,s_tens,s_units}, 4 bits each, updates on tick_1s
alarm  in  24  alarm value, same packing; 24'hFFFFFF = no alarm set
alarm_ready  in  1  level; alarm value valid and armed
tick_1s  in  1  one-cycle pulse per second from the clock block
stop_filtered  in  1  debounced one-cycle stop key pulse
snooze_filtered  in  1  debounced one-cycle snooze key pulse
buzzer  out  1  buzzer drive, active-high
ringing  out  1  high in RING state
alarm_hit  out  1  one-cycle pulse on the ARMED->RING transition
alarm_state  out  2  00 IDLE, 01 ARMED, 10 RING, 11 SNOOZE

Behaviour:
- Reset (async, rst=1): state IDLE; buzzer=0, ringing=0, alarm_hit=0, alarm_state=00; all counters and match_q cleared.
- valid = alarm_ready && (alarm != 24'hFFFFFF). match = (time_bcd == alarm), full 24-bit compare, registered into match_q every cycle. hit = match && !match_q (rising edge only, so the same second cannot retrigger after stop).
- Transitions (registered, take effect next cycle):
  - IDLE -> ARMED when valid.
  - ARMED -> RING on hit; alarm_hit pulses on the cycle state becomes RING.
  - RING -> ARMED on stop_filtered, or when ring_cnt reaches RING_SEC (ring_cnt increments on tick_1s while in RING).
  - RING -> SNOOZE on snooze_filtered (subject to the limit, see Optional Feature).
  - SNOOZE -> RING when snz_cnt reaches SNOOZE_SEC (counts tick_1s); alarm_hit does not pulse on this re-ring.
  - SNOOZE -> ARMED on stop_filtered.
  - Any state -> IDLE when valid drops; this has highest priority.
- Simultaneous events: stop beats snooze; a hit while in RING or SNOOZE is ignored; a tick on the same cycle as stop is not counted.
- ring_cnt, tone and gate counters clear on every entry to RING. snz_cnt clears on entry to SNOOZE. The snooze counter clears on entry to ARMED.
- Buzzer:
  - tone is a square wave toggling every TONE_DIV cycles; gate toggles every CLK_FREQ/2 cycles; both start high at RING entry.
  - buzzer = tone & gate in RING, 0 in every other state, registered.
  - First buzzer high occurs 1 cycle after entering RING.
- Counter widths: $clog2 of the parameter +1. Counters never wrap while in RING or SNOOZE.
- ringing = (state==RING); alarm_state is a direct state encoding.

Optional Feature:
- SNOOZE_LIMIT_EN defined: snooze_cnt counts accepted snoozes per alarm event. A snooze_filtered press when snooze_cnt == MAX_SNOOZE is ignored, and ringing continues until stop or RING_SEC.
- SNOOZE_LIMIT_EN undefined: snoozes are unlimited; MAX_SNOOZE is unused and no snooze counter is built.

Test Plan:
Bench parameters: CLK_FREQ=20, TONE_DIV=2, RING_SEC=3, SNOOZE_SEC=2, MAX_SNOOZE=2; tick_1s every 20 cycles.
- Reset held with alarm_ready=1 -> all outputs 0, alarm_state=00. Release with alarm=24'h070000 -> alarm_state=01 next cycle. Release with alarm=24'hFFFFFF -> stays 00.
- time_bcd steps 24'h065959 -> 24'h070000 -> alarm_hit one-cycle pulse, alarm_state=10. buzzer pattern: high 2 / low 2 cycles for 10 cycles, then low 10 cycles, repeating.
- Ringing with no key -> after 3 ticks alarm_state=01, buzzer=0. time_bcd held at 24'h070000 causes no retrigger.
- Ringing, stop_filtered and snooze_filtered on the same cycle -> ARMED (stop wins).
- Ringing, snooze_filtered -> 11. After 2 ticks -> 10 with no alarm_hit pulse. stop in SNOOZE -> 01.
- SNOOZE_LIMIT_EN defined: a third snooze in one event is ignored (state stays 10). Separately, alarm_ready dropped mid-RING -> 00 and buzzer=0 next cycle.
